elevator_ctrl: RTL
==================

# elevator_ctrl

- Three-floor car controller that sits directly downstream of the 3-bit button debouncer.
- Consumes the debounced `btn[2:0]` levels and detects rising edges to latch floor requests.
- Runs a direction-preserving (SCAN) state machine that moves the car one floor per travel interval and opens the door at requested floors.
- Drives the floor indicator and status outputs for the display logic.

## Interface
Parameters:
- `TRAVEL_CYCLES`, default 50_000_000: clock cycles per one-floor move; legal range ≥ 2.
- `DOOR_CYCLES`, default 100_000_000: clock cycles the door stays open; legal range ≥ 2.

Ports:
- `clk` input 1: single system clock; every register is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `btn` input 3: debounced floor buttons, already synchronous to `clk`; bit i is floor i.
- `floor` output 2: current car floor, 0..2; value 3 never appears.
- `pending` output 3: latched outstanding requests; bit i is floor i.
- `moving_up` output 1: high while in state UP.
- `moving_down` output 1: high while in state DOWN.
- `door_open` output 1: high while in state DOOR.

## Operation
Edge detection:
- `btn_q` registers `btn`; `rise = btn & ~btn_q`.
- `btn_q` resets to 0, so a button held through reset release counts as a press on the first edge.

Request latch:
- On each edge: `pending <= (pending | rise) & ~clr`.
- `clr` is the one-hot of `floor`, asserted only on the edge that enters DOOR.
- In the same cycle, set and clear on different bits are independent.
- In the same cycle, set and clear on the same bit: clear wins.
- A press at the current floor while in DOOR is ignored (but see Configuration).

Direction register `last_dir`: 1 = up; resets to 1.

States IDLE, UP, DOWN, DOOR. Reset state is IDLE.

IDLE evaluates, in priority order:
- `pending[floor]` → DOOR.
- `last_dir=1` and any pending above → UP.
- Any pending below → DOWN, set `last_dir=0`.
- Any pending above → UP, set `last_dir=1`.
- Otherwise stay in IDLE.

UP/DOWN:
- On entry, load the 32-bit `timer` with `TRAVEL_CYCLES-1`; decrement each cycle.
- In the cycle where `timer==0`: `floor` ±1, go to IDLE.
- Requests arriving during travel are latched and considered at the next IDLE evaluation.

DOOR:
- On entry, load `timer` with `DOOR_CYCLES-1` and clear `pending[floor]`.
- When `timer==0`, go to IDLE.

Guarantees:
- UP is never entered at floor 2; DOWN is never entered at floor 0.
- `floor` saturates by construction, with no wrap.

Reset values: `floor=0`, `pending=0`, `moving_up=0`, `moving_down=0`, `door_open=0`, `timer=0`, `last_dir=1`.

Reset mid-operation: the car returns instantly to floor 0, IDLE, with all requests dropped. There is no partial-move completion.

## Timing
- All outputs are registered or decoded directly from registered state; no combinational path from `btn` to any output.
- `btn` high at edge N (with `btn_q=0`) → `pending` bit set after edge N.
- IDLE acts on it at edge N+1: the state/output change is visible after N+1.
- A one-floor move keeps `moving_*` high for exactly `TRAVEL_CYCLES` cycles; `floor` updates on the same edge that `moving_*` falls.
- A multi-floor trip adds one IDLE cycle between consecutive floors.
- `door_open` is high for exactly `DOOR_CYCLES` cycles, followed by at least one IDLE cycle.
- Press-at-current-floor latency from IDLE: `door_open` rises 2 edges after `btn` rises.

## Configuration
`ELEV_DOOR_HOLD_EN`:
- Defined: a `rise` on `btn[floor]` while in DOOR reloads `timer` with `DOOR_CYCLES-1`, extending the open interval. The pending bit stays clear.
- Undefined: that press is ignored entirely; the door closes on schedule.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `TRAVEL_CYCLES=4`, `DOOR_CYCLES=3`.
- Reset then idle: assert `rst` mid-cycle → all outputs 0 asynchronously; with `btn=0`, the state stays IDLE for 20 cycles.
- Press floor 0 at floor 0: `btn=001` for 1 cycle → `pending=001` after edge 0; `door_open=1` for 3 cycles starting after edge 1, with `pending` cleared on that edge.
- Press floor 2: `btn=100` from floor 0 → `moving_up=1` for 4 cycles, `floor=1`, one IDLE cycle, 4 more UP cycles, `floor=2`, then 3 cycles of `door_open`.
- SCAN order: start at floor 1 with `last_dir=1` and `pending=101` set in the same cycle → goes UP to 2 first, then DOWN to 0; `last_dir=0` after the reversal.
- Reset mid-move: assert `rst` during UP at `timer=2` → `floor=0`, `pending=0`, `moving_up=0` immediately; the car stays IDLE after release.
- Door hold: with the door open at floor 1, re-press `btn[1]` at door cycle 2.
  - With `ELEV_DOOR_HOLD_EN`: the door is open 5 cycles total.
  - Without it: the door is open 3 cycles and `pending` stays 000.

Source files
------------

// File: rtl/elevator_ctrl.sv
// Three-floor SCAN elevator controller: latches debounced button edges, moves one floor per
// travel interval, holds the door open at requested floors. Optional macro: ELEV_DOOR_HOLD_EN.
module elevator_ctrl #(
  parameter int unsigned TRAVEL_CYCLES = 50_000_000,
  parameter int unsigned DOOR_CYCLES   = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  output logic [1:0] floor,
  output logic [2:0] pending,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

  localparam logic [31:0] TRAVEL_LOAD = 32'(TRAVEL_CYCLES - 1);
  localparam logic [31:0] DOOR_LOAD   = 32'(DOOR_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic [1:0]  floor_nxt;
  logic        last_dir, last_dir_nxt;
  logic [2:0]  btn_q, rise, here, clr, set, above, below;
  logic        hold;

  assign rise = btn & ~btn_q;
  assign here = 3'b001 << floor;

  always_comb begin
    above = 3'b000;
    below = 3'b000;
    case (floor)
      2'd0:    above = pending & 3'b110;
      2'd1:    begin above = pending & 3'b100; below = pending & 3'b001; end
      default: below = pending & 3'b011;
    endcase
  end

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = (state == DOOR) && |(rise & here);
`else
  assign hold = 1'b0;
`endif

  // A press at the current floor while the door is open never re-latches a request.
  assign set = (state == DOOR) ? (rise & ~here) : rise;

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    floor_nxt    = floor;
    last_dir_nxt = last_dir;
    clr          = 3'b000;
    case (state)
      IDLE: begin
        if (|(pending & here)) begin
          state_nxt = DOOR;
          timer_nxt = DOOR_LOAD;
          clr       = here;
        end else if (last_dir && |above) begin
          state_nxt = UP;
          timer_nxt = TRAVEL_LOAD;
        end else if (|below) begin
          state_nxt    = DOWN;
          timer_nxt    = TRAVEL_LOAD;
          last_dir_nxt = 1'b0;
        end else if (|above) begin
          state_nxt    = UP;
          timer_nxt    = TRAVEL_LOAD;
          last_dir_nxt = 1'b1;
        end
      end
      UP: begin
        if (timer == 32'd0) begin
          floor_nxt = floor + 2'd1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      DOWN: begin
        if (timer == 32'd0) begin
          floor_nxt = floor - 2'd1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      DOOR: begin
        if (hold) begin
          timer_nxt = DOOR_LOAD;
        end else if (timer == 32'd0) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= 32'd0;
      floor    <= 2'd0;
      last_dir <= 1'b1;
      btn_q    <= 3'b000;
      pending  <= 3'b000;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      floor    <= floor_nxt;
      last_dir <= last_dir_nxt;
      btn_q    <= btn;
      pending  <= (pending | set) & ~clr;
    end
  end

  assign moving_up   = (state == UP);
  assign moving_down = (state == DOWN);
  assign door_open   = (state == DOOR);

endmodule
